// File: rtl/thermo_pkg.sv
// Shared types and helpers for the thermometer-to-binary decoder.
package thermo_pkg;

  localparam int SEG_DEFAULT = 32;
  // Segment index field is sized for the largest supported segment; the top truncates it.
  localparam int IDX_MAX_W   = 16;

  function automatic int LOG2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  typedef struct packed {
    logic                 full;
    logic [IDX_MAX_W-1:0] idx;
    logic                 bub;
    logic                 lsb;
  } seg_res_t;

endpackage

// File: rtl/thermo_seg_decode.sv
// Combinational decode of one thermometer segment: all-ones, lowest zero, bubble, low bit.
// Bubble detection exists only when THERMO_BUBBLE_CHECK_EN is defined.
module thermo_seg_decode
  import thermo_pkg::*;
#(
  parameter int SEG = SEG_DEFAULT
) (
  input  logic [SEG-1:0] seg_i,
  output seg_res_t       res_o
);

  always_comb begin
    res_o      = '0;
    res_o.full = &seg_i;
    res_o.lsb  = seg_i[0];
    for (int j = SEG - 1; j >= 0; j--) begin
      if (!seg_i[j]) res_o.idx = IDX_MAX_W'(j);
    end
`ifdef THERMO_BUBBLE_CHECK_EN
    res_o.bub = |(seg_i[SEG-1:1] & ~seg_i[SEG-2:0]);
`endif
  end

endmodule

// File: rtl/thermo_decoder.sv
// Two-stage thermometer-to-binary decoder with valid/ready flow control.
// Optional bubble flag under THERMO_BUBBLE_CHECK_EN; otherwise out_err is tied low.
module thermo_decoder
  import thermo_pkg::*;
#(
  parameter int WIDTH = 1024,
  parameter int LOG_W = 10,
  parameter int SEG   = SEG_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] thermo,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [LOG_W:0]   enc,
  output logic             out_err
);

  localparam int NSEG  = WIDTH / SEG;
  localparam int SBITS = LOG2(SEG);
  localparam int EW    = LOG_W + 1;

  seg_res_t         res [NSEG];
  logic [NSEG-1:0]  unused_res;
  logic             adv;

  logic [NSEG-1:0]  full_d, full_p1_q;
  logic [SBITS-1:0] idx_d [NSEG];
  logic [SBITS-1:0] idx_p1_q [NSEG];
  logic             vld_p1_q, vld_p2_q;
  logic [LOG_W:0]   enc_d, enc_q;

  assign adv       = out_ready | ~vld_p2_q;
  assign in_ready  = adv;
  assign out_valid = vld_p2_q;
  assign enc       = enc_q;

  for (genvar s = 0; s < NSEG; s++) begin : g_seg
    thermo_seg_decode #(.SEG(SEG)) u_seg (
      .seg_i (thermo[s*SEG +: SEG]),
      .res_o (res[s])
    );
    assign unused_res[s] = ^res[s];
  end

  always_comb begin
    for (int s = 0; s < NSEG; s++) begin
      full_d[s] = res[s].full;
      idx_d[s]  = res[s].idx[SBITS-1:0];
    end
  end

  // Stage 2 combinational: lowest non-full segment wins
  always_comb begin
    enc_d = EW'(WIDTH);
    for (int s = NSEG - 1; s >= 0; s--) begin
      if (!full_p1_q[s]) enc_d = EW'(s * SEG) + EW'(idx_p1_q[s]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1_q  <= 1'b0;
      vld_p2_q  <= 1'b0;
      full_p1_q <= '0;
      enc_q     <= '0;
      for (int s = 0; s < NSEG; s++) idx_p1_q[s] <= '0;
    end else if (adv) begin
      // Stage 1 boundary
      vld_p1_q  <= in_valid;
      full_p1_q <= full_d;
      for (int s = 0; s < NSEG; s++) idx_p1_q[s] <= idx_d[s];
      // Stage 2 boundary
      vld_p2_q  <= vld_p1_q;
      enc_q     <= enc_d;
    end
  end

`ifdef THERMO_BUBBLE_CHECK_EN
  logic [NSEG-1:0] lsb_vec, bub_vec, bub_d, bub_p1_q;
  logic            err_q;

  always_comb begin
    for (int s = 0; s < NSEG; s++) begin
      lsb_vec[s] = res[s].lsb;
      bub_vec[s] = res[s].bub;
    end
    // A set low bit in segment s+1 above a non-full segment s is a boundary bubble.
    bub_d = bub_vec | ((lsb_vec >> 1) & ~full_d);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bub_p1_q <= '0;
      err_q    <= 1'b0;
    end else if (adv) begin
      bub_p1_q <= bub_d;
      err_q    <= |bub_p1_q;
    end
  end

  assign out_err = err_q;
`else
  assign out_err = 1'b0;
`endif

endmodule

// File: tb/tb_thermo_decoder.sv
// Randomized self-checking bench for thermo_decoder against a lowest-zero reference model.
module tb_thermo_decoder;

  localparam int W   = 1024;
  localparam int LW  = 10;
  localparam int SG  = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  thermo = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [LW:0]   enc;
  logic          out_err;

  int checks = 0;
  int failures = 0;

  int exp_enc_q[$];
  int exp_err_q[$];
  bit held_v = 1'b0;
  int held_enc = 0;
  int held_err = 0;

  always #5 clk = ~clk;

  thermo_decoder #(.WIDTH(W), .LOG_W(LW), .SEG(SG)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .thermo    (thermo),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .enc       (enc),
    .out_err   (out_err)
  );

  task automatic chk_eq(input string tag, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] ones(input int n);
    logic [W-1:0] r;
    r = '0;
    for (int i = 0; i < n; i++) r[i] = 1'b1;
    return r;
  endfunction

  function automatic int ref_enc(input logic [W-1:0] t);
    for (int i = 0; i < W; i++) if (!t[i]) return i;
    return W;
  endfunction

  // A vector is a bubble iff any bit above its lowest zero is set.
  function automatic int ref_err(input logic [W-1:0] t);
`ifdef THERMO_BUBBLE_CHECK_EN
    int e;
    e = ref_enc(t);
    for (int i = e + 1; i < W; i++) if (t[i]) return 1;
`endif
    return 0;
  endfunction

  task automatic step(input logic v, input logic [W-1:0] t, input logic rdy, output bit acc);
    @(negedge clk);
    in_valid  = v;
    thermo    = t;
    out_ready = rdy;
    #1;
    if (held_v && out_valid) begin
      chk_eq("hold_enc", enc, held_enc);
      chk_eq("hold_err", out_err, held_err);
    end
    held_v   = out_valid && !out_ready;
    held_enc = enc;
    held_err = out_err;
    if (out_valid && out_ready) begin
      if (exp_enc_q.size() == 0) begin
        chk_eq("spurious_out", 1, 0);
      end else begin
        chk_eq("enc", enc, exp_enc_q.pop_front());
        chk_eq("out_err", out_err, exp_err_q.pop_front());
      end
    end
    acc = v && in_ready;
    if (acc) begin
      exp_enc_q.push_back(ref_enc(t));
      exp_err_q.push_back(ref_err(t));
    end
  endtask

  task automatic drain();
    bit a;
    for (int i = 0; i < 20 && exp_enc_q.size() != 0; i++) step(1'b0, '0, 1'b1, a);
    chk_eq("drain_empty", exp_enc_q.size(), 0);
  endtask

  task automatic send(input logic [W-1:0] t);
    bit a;
    step(1'b1, t, 1'b1, a);
    chk_eq("send_acc", a, 1);
  endtask

  initial begin
    bit a;
    int tgt[8] = '{0, 1, 31, 32, 33, 511, 1023, 1024};
    int idx, acc_cnt, n;
    logic [W-1:0] t;

    repeat (2) @(posedge clk);
    #1;
    chk_eq("rst_out_valid", out_valid, 0);
    chk_eq("rst_enc", enc, 0);
    chk_eq("rst_out_err", out_err, 0);
    chk_eq("rst_in_ready", in_ready, 1);
    @(negedge clk);
    rst = 1'b0;

    // Latency: two edges from the accepting edge's capture to out_valid
    send('0);
    step(1'b0, '0, 1'b1, a);
    chk_eq("lat_edge1", out_valid, 0);
    step(1'b0, '0, 1'b1, a);
    chk_eq("lat_edge2", out_valid, 1);
    drain();

    send(ones(37));
    send(ones(W));
    drain();

    // Back-pressure with out_ready toggling
    idx = 0;
    for (int c = 0; c < 100 && idx < 8; c++) begin
      step(1'b1, ones(tgt[idx]), (c % 2) == 0, a);
      if (a) idx++;
    end
    chk_eq("toggle_all_sent", idx, 8);
    drain();

    // Bubble patterns
    t = '0; t[0] = 1'b1; t[2] = 1'b1;
    send(t);
    t = ones(32); t[40] = 1'b1;
    send(t);
    drain();

    // Reset with two beats in flight
    send(ones(5));
    send(ones(6));
    @(negedge clk);
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk_eq("midrst_out_valid", out_valid, 0);
    chk_eq("midrst_enc", enc, 0);
    chk_eq("midrst_in_ready", in_ready, 1);
    exp_enc_q.delete();
    exp_err_q.delete();
    held_v = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step(1'b0, '0, 1'b1, a);
      chk_eq("post_rst_idle", out_valid, 0);
    end

    // Random full-rate traffic, occasional bubbles
    acc_cnt = 0;
    for (int i = 0; i < 300; i++) begin
      n = $urandom_range(0, W);
      t = ones(n);
      if (($urandom % 4) == 0) t[$urandom_range(0, W - 1)] = 1'b1;
      step(1'b1, t, 1'b1, a);
      if (a) acc_cnt++;
    end
    chk_eq("full_rate_accepts", acc_cnt, 300);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/thermo_decoder.md
# thermo_decoder

Pipelined thermometer-to-binary decoder for the programmable priority encoder datapath; the inverse of the binary-to-thermometer mask generator. Accepts a WIDTH-bit thermometer vector over a valid/ready handshake and returns the binary count of its contiguous low-order ones, with optional bubble (non-thermometer pattern) detection. Sits downstream of the mask/compare stage, where masked request vectors are converted back to grant indices.

## Interface
- WIDTH, 1024: thermometer vector width; power of two, multiple of SEG
- LOG_W, 10: log2(WIDTH)
- SEG, 32: segment width for the stage-1 split; power of two, 4..WIDTH
- clk  input  1  clock, all state on rising edge
- rst  input  1  reset; one clock, asynchronous and active-high
- in_valid  input  1  thermo is valid
- in_ready  output  1  decoder can accept this cycle
- thermo  input  WIDTH  thermometer vector; bit 0 is the low end
- out_valid  output  1  enc/out_err valid
- out_ready  input  1  downstream accepts enc
- enc  output  LOG_W+1  index of lowest zero bit of thermo; WIDTH when all ones
- out_err  output  1  bubble detected in the corresponding input

## Operation
- Result definition: enc = min{i : thermo[i]==0}, or WIDTH if thermo is all ones. Well defined for any input, thermometer or not.
- Stage 1 (registered): thermo split into WIDTH/SEG segments; per segment s: full[s] (all ones), idx[s] (LOG2(SEG) bits, lowest zero within segment, 0 if full), bub[s] (some bit j>0 set with bit j-1 clear, inside segment), plus boundary bubble flag (lowest bit of segment s+1 set while segment s not full).
- Stage 2 (registered): k = lowest s with full[s]==0; enc = k*SEG + idx[k]; if no such s, enc = WIDTH. out_err = OR of all bubble flags. Arithmetic is unsigned, LOG_W+1 bits, no overflow possible.
- Bubble examples: 0x...0005 is a bubble; 0x0, 0x1, 0x3, all-ones are not.
- Handshake: pipeline advances when adv = out_ready | ~out_valid; in_ready = adv (combinational from out_ready and out_valid). Beat accepted when in_valid & in_ready; result delivered when out_valid & out_ready.
- Stall: when adv==0 every stage register and valid holds; enc/out_err stable while out_valid & ~out_ready.
- Bubbles in the pipeline (stage-1 empty) collapse when adv==1; no beat is ever duplicated or dropped.

## Timing
- Latency: 2 cycles from accepting edge to out_valid, absent back-pressure.
- Throughput: one beat per cycle with out_ready held high.
- Reset (async assert, sync-safe deassert handled externally): stage valids 0, out_valid 0, enc 0, out_err 0, all stage data 0; in_ready reads 1 immediately after reset.
- Reset mid-operation: in-flight beats discarded; no out_valid until a new beat is accepted after reset release.
- Simultaneous accept and deliver in one cycle: legal, full rate.
- in_valid with in_ready low: the input is not captured; the source must hold.

## Configuration
- THERMO_BUBBLE_CHECK_EN defined: bubble flags computed and pipelined; out_err as above.
- Not defined: bubble logic absent; out_err tied 0; enc behaviour and latency unchanged.

## Structure
- Package thermo_pkg: SEG default, LOG2 helper function, segment-result struct (full, idx, bub, lsb) typedef.
- Sub-module thermo_seg_decode: combinational single-segment full/idx/bub/lsb, instantiated WIDTH/SEG times in stage 1.
- Top holds the two pipeline registers, segment priority select and handshake.

## Test plan
- Reset then thermo=0x0, one beat, out_ready=1 -> out_valid 2 cycles later, enc=0, out_err=0.
- thermo with bits [36:0] set (WIDTH=1024) -> enc=37 (segment boundary crossing), out_err=0; all ones -> enc=1024.
- Back-to-back 8 beats enc targets 0,1,31,32,33,511,1023,1024 with out_ready toggling 1,0 -> outputs in order, each held stable while out_ready=0, none lost.
- thermo=0x5 and separately bits [31:0] set plus bit 40 -> enc=1 and enc=32, out_err=1 with macro, 0 without.
- Assert rst while 2 beats in flight -> out_valid=0, enc=0 immediately; no stale beats after release.
- Random thermometer vectors at full rate vs reference model (lowest-zero index) -> exact match, 1 beat/cycle sustained.
